// File: rtl/nn_mac_neuron.sv
// Multiply-accumulate neuron: streams unsigned activations against signed weights onto a
// biased saturating accumulator, then shifts, clamps (ReLU or signed) and hands off one result.
module nn_mac_neuron #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int N_IN   = 16,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [ACC_W-1:0]  bias,
  input  logic              relu_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_act,
  input  logic [DATA_W-1:0] in_wgt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              busy
);

  localparam int CNT_W  = $clog2(N_IN + 1);
  localparam int PROD_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                   state, state_next;
  logic signed [ACC_W-1:0]  acc, acc_sum, shifted;
  logic signed [ACC_W:0]    sum_wide;
  logic signed [DATA_W:0]   act_ext;
  logic signed [PROD_W-1:0] prod;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_W-1:0]        result;
  logic                     ovf, relu_q, sum_ovf, beat, last_beat;

  assign in_ready  = ena && (state == ACCUM);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt == CNT_W'(N_IN - 1));

  // Activation gets a zero sign bit so the signed multiply treats it as unsigned.
  assign act_ext  = {1'b0, in_act};
  assign prod     = PROD_W'(act_ext) * PROD_W'($signed(in_wgt));
  assign sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(ACC_W'(prod));
  assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign acc_sum  = !sum_ovf          ? sum_wide[ACC_W-1:0] :
                    sum_wide[ACC_W]   ? {1'b1, {(ACC_W-1){1'b0}}} :
                                        {1'b0, {(ACC_W-1){1'b1}}};
  assign shifted  = acc_sum >>> SHIFT;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    result = shifted[DATA_W-1:0];
    if (relu_q) begin
      if (shifted[ACC_W-1])                result = '0;
      else if (|shifted[ACC_W-2:DATA_W])   result = '1;
    end else if (!(&shifted[ACC_W-1:DATA_W-1]) && (|shifted[ACC_W-1:DATA_W-1])) begin
      result = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = ACCUM;
      ACCUM:   if (last_beat) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)   state <= IDLE;
    else if (ena) state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      relu_q   <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: if (start) begin
          acc    <= bias;
          cnt    <= '0;
          ovf    <= 1'b0;
          relu_q <= relu_en;
        end
        ACCUM: if (beat) begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
          ovf <= ovf | sum_ovf;
          if (last_beat) begin
            out_data <= result;
            out_ovf  <= ovf | sum_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mac_neuron.sv
// Bench for nn_mac_neuron: a 24-bit and a 17-bit accumulator instance share one stimulus
// stream and are checked against an integer reference model of the neuron arithmetic.
module tb_nn_mac_neuron;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int SH = 2;
  localparam int AWA = 24;
  localparam int AWB = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, ena, start, relu_en, in_valid, out_ready;
  logic [AWA-1:0] bias;
  logic [DW-1:0]  in_act, in_wgt;
  logic           a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic           b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [DW-1:0]  a_out_data, b_out_data;

  nn_mac_neuron #(.DATA_W(DW), .ACC_W(AWA), .N_IN(N), .SHIFT(SH)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .bias(bias), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ovf(a_out_ovf), .busy(a_busy));

  nn_mac_neuron #(.DATA_W(DW), .ACC_W(AWB), .N_IN(N), .SHIFT(SH)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .bias(bias[AWB-1:0]), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ovf(b_out_ovf), .busy(b_busy));

  int errors = 0;
  int checks = 0;
  int acts[N];
  int wgts[N];
  logic [DW-1:0] exp_a_data, exp_b_data;
  bit            exp_a_ovf, exp_b_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: clamp after every add, then floor-shift and clamp to the output range.
  function automatic void model(input longint b, input bit relu, input int aw,
                                output logic [DW-1:0] d, output bit o);
    longint maxv, minv, acc, s;
    maxv = (longint'(1) <<< (aw - 1)) - 1;
    minv = -maxv - 1;
    acc  = b;
    o    = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc += longint'(acts[i]) * longint'(wgts[i]);
      if (acc > maxv)      begin acc = maxv; o = 1'b1; end
      else if (acc < minv) begin acc = minv; o = 1'b1; end
    end
    s = acc >>> SH;
    if (relu) d = (s < 0) ? 8'h00 : (s > 255) ? 8'hFF : 8'(s);
    else      d = (s < -128) ? 8'h80 : (s > 127) ? 8'h7F : 8'(s);
  endfunction

  function automatic void fill(input int a, input int w);
    for (int i = 0; i < N; i++) begin
      acts[i] = a;
      wgts[i] = w;
    end
  endfunction

  task automatic begin_neuron(input logic [AWA-1:0] b, input bit r);
    logic [AWB-1:0] b17;
    b17 = b[AWB-1:0];
    model(longint'($signed(b)), r, AWA, exp_a_data, exp_a_ovf);
    model(longint'($signed(b17)), r, AWB, exp_b_data, exp_b_ovf);
    start = 1'b1; bias = b; relu_en = r; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("busy_after_start_a", a_busy, 1'b1);
    check("busy_after_start_b", b_busy, 1'b1);
  endtask

  // vmode: 0 = valid held, 1 = valid toggling 1-0, 2 = random. ena drops for 3 cycles at stall_at.
  task automatic feed(input int vmode, input int stall_at, output int edges);
    int idx;
    idx = 0;
    edges = 0;
    while (idx < N && edges < 100) begin
      bit v, en;
      v  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (edges % 2 == 0) : ($urandom_range(1) == 1);
      en = !(stall_at >= 0 && edges >= stall_at && edges < stall_at + 3);
      in_valid = v; ena = en;
      in_act = 8'(acts[idx]); in_wgt = 8'(wgts[idx]);
      #1;
      check("in_ready_accum_a", a_in_ready, en);
      check("in_ready_accum_b", b_in_ready, en);
      @(posedge clk);
      edges++;
      if (v && en) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0; ena = 1'b1;
    if (idx < N) check("feed_timeout", idx, N);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid_a"}, a_out_valid, 1'b1);
    check({tag, "_data_a"},  a_out_data, exp_a_data);
    check({tag, "_ovf_a"},   a_out_ovf, exp_a_ovf);
    check({tag, "_valid_b"}, b_out_valid, 1'b1);
    check({tag, "_data_b"},  b_out_data, exp_b_data);
    check({tag, "_ovf_b"},   b_out_ovf, exp_b_ovf);
  endtask

  // Holds out_ready low with start pulses and junk beats, optionally blocks a handshake with ena=0.
  task automatic finish_out(input int hold, input bit ena_block);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0; start = 1'b1; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      check("hold_valid_a", a_out_valid, 1'b1);
      check("hold_data_a",  a_out_data, exp_a_data);
      check("hold_data_b",  b_out_data, exp_b_data);
      check("hold_in_ready_a", a_in_ready, 1'b0);
    end
    start = 1'b0; in_valid = 1'b0;
    if (ena_block) begin
      ena = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("ena_blocks_handshake", a_out_valid, 1'b1);
      ena = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("idle_valid_a", a_out_valid, 1'b0);
    check("idle_busy_a",  a_busy, 1'b0);
    check("idle_valid_b", b_out_valid, 1'b0);
    check("idle_in_ready_a", a_in_ready, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; bias = '0; in_act = '0; in_wgt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_ready", a_in_ready, 1'b0);
    check("rst_busy",  a_busy, 1'b0);
    check("rst_data",  a_out_data, 8'h00);
    check("rst_ovf",   a_out_ovf, 1'b0);
    rst_n = 1'b1;

    // Basic: 4 x (10*3) = 120, >>>2 = 30; beats presented in IDLE are ignored first.
    in_valid = 1'b1; #1;
    check("idle_ignores_beats", a_in_ready, 1'b0);
    @(negedge clk);
    fill(10, 3);
    begin_neuron(24'd0, 1'b1);
    feed(0, -1, edges);
    check("basic_latency", edges, N);
    check("basic_data_const", a_out_data, 8'd30);
    check_result("basic");
    finish_out(0, 1'b0);

    fill(10, -3);
    begin_neuron(24'd0, 1'b1);
    feed(0, -1, edges);
    check("neg_relu_const", a_out_data, 8'h00);
    check_result("neg_relu");
    finish_out(0, 1'b0);
    begin_neuron(24'd0, 1'b0);
    feed(0, -1, edges);
    check("neg_signed_const", a_out_data, 8'hE2);
    check_result("neg_signed");
    finish_out(0, 1'b0);

    fill(255, 127);
    begin_neuron(24'd0, 1'b1);
    feed(0, -1, edges);
    check("clamp_relu_const", a_out_data, 8'hFF);
    check("clamp_relu_ovf", a_out_ovf, 1'b0);
    check_result("clamp_relu");
    finish_out(0, 1'b0);
    begin_neuron(24'd0, 1'b0);
    feed(0, -1, edges);
    check("clamp_signed_const", a_out_data, 8'h7F);
    check_result("clamp_signed");
    finish_out(0, 1'b0);

    // 17-bit accumulator saturates at 65535 and flags out_ovf.
    begin_neuron(24'd65000, 1'b1);
    feed(0, -1, edges);
    check("sat_relu_ovf_b", b_out_ovf, 1'b1);
    check("sat_relu_data_b", b_out_data, 8'hFF);
    check_result("sat_relu");
    finish_out(0, 1'b0);
    begin_neuron(24'd65000, 1'b0);
    feed(0, -1, edges);
    check("sat_signed_ovf_b", b_out_ovf, 1'b1);
    check("sat_signed_data_b", b_out_data, 8'h7F);
    check_result("sat_signed");
    finish_out(0, 1'b0);

    // Toggling in_valid, then a 5-cycle stall on out_ready with start pulses.
    fill(10, 3);
    acts[1] = 7; wgts[2] = -5;
    begin_neuron(24'd5, 1'b0);
    feed(1, -1, edges);
    check("toggle_latency", edges, 2 * N - 1);
    check_result("toggle");
    finish_out(5, 1'b1);

    // Reset after two beats aborts the neuron; reset wins over ena=0.
    fill(10, 3);
    begin_neuron(24'd0, 1'b1);
    in_valid = 1'b1; in_act = 8'd10; in_wgt = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_valid", a_out_valid, 1'b0);
    check("midrst_busy",  a_busy, 1'b0);
    check("midrst_data",  a_out_data, 8'h00);
    check("midrst_ovf",   a_out_ovf, 1'b0);
    check("midrst_ready", a_in_ready, 1'b0);
    rst_n = 1'b1; ena = 1'b1;
    begin_neuron(24'd0, 1'b1);
    feed(0, -1, edges);
    check("after_rst_data", a_out_data, 8'd30);
    check_result("after_rst");
    finish_out(0, 1'b0);

    // ena low for 3 cycles mid-ACCUM stretches latency by exactly 3.
    begin_neuron(24'd0, 1'b1);
    feed(0, 1, edges);
    check("stall_latency", edges, N + 3);
    check("stall_data", a_out_data, 8'd30);
    check_result("stall");
    finish_out(0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        acts[i] = int'($urandom_range(255));
        wgts[i] = int'($urandom_range(255)) - 128;
      end
      begin_neuron(24'($urandom), 1'($urandom_range(1)));
      feed(2, ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1, edges);
      check_result("rand");
      finish_out(int'($urandom_range(2)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_mac_neuron.md
# nn_mac_neuron

Parametrised multiply-accumulate neuron engine for the MNIST accelerator top level. It consumes a stream of unsigned activations paired with signed weights and adds a signed bias. It then applies an arithmetic shift, optional ReLU and output saturation. The result is presented on a valid/ready output port. One instance computes one neuron; the top level time-multiplexes it across layers via the input stream.

## Interface

- DATA_W, 8, width of activations, weights and output data.
- ACC_W, 24, signed accumulator width. Must be ≥ 2*DATA_W+1.
- N_IN, 16, number of activation/weight beats per neuron. Must be ≥ 1.
- SHIFT, 4, arithmetic right shift applied to the accumulator before output clamping.

Ports:

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable. Low freezes all registers and forces in_ready low.
- start  in  1  begin a neuron; sampled only in IDLE.
- bias  in  ACC_W  signed bias, captured on accepted start.
- relu_en  in  1  output mode, captured on accepted start. 1 = ReLU/unsigned clamp; 0 = signed clamp.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts a beat.
- in_act  in  DATA_W  unsigned activation.
- in_wgt  in  DATA_W  signed (two's complement) weight.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  result; unsigned if ReLU mode, two's complement otherwise.
- out_ovf  out  1  accumulator saturated during this neuron; valid with out_valid.
- busy  out  1  high in ACCUM or OUT.

## Operation

- FSM states: IDLE, ACCUM, OUT.
- IDLE -> ACCUM on start=1 with ena=1. On that edge:
  - acc <= bias
  - cnt <= 0
  - ovf <= 0
  - relu_en is latched.
- ACCUM: in_ready=1 (when ena=1).
  - A beat is accepted when in_valid & in_ready.
  - On each accepted beat: acc <= sat(acc + prod), cnt <= cnt+1.
  - Cycles with no accepted beat leave acc and cnt unchanged.
- Product rule: prod = zero-extend(in_act) × sign-extend(in_wgt), a (2*DATA_W+1)-bit signed value sign-extended to ACC_W.
- Accumulate rule: saturating signed add. On overflow, acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1), and ovf is set sticky for the neuron.
- ACCUM -> OUT on the edge accepting beat N_IN. The result is computed from the final accumulator value and registered into out_data on that same edge.
- Result computation:
  - s = acc >>> SHIFT (arithmetic shift).
  - ReLU mode: s<0 → 0; s>2^DATA_W-1 → 2^DATA_W-1; otherwise s.
  - Signed mode: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Output clamping does not set out_ovf.
- OUT: out_valid=1, and out_data/out_ovf are held stable. On out_valid & out_ready → IDLE, and out_valid drops next cycle.
- start while in ACCUM or OUT is ignored. It is not queued.
- in_ready=0 in IDLE and OUT. Beats presented there are not consumed.
- busy = (state != IDLE).

## Timing

- Reset values (rst_n=0 at an edge): state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0.
- Reset mid-operation aborts the neuron. No partial result is emitted.
- Reset has priority over ena.
- Latency, with start accepted at edge E0 and in_valid held high: beat k is accepted at edge E0+k, and out_valid is high in the cycle after edge E0+N_IN. Minimum start-to-valid is N_IN+1 cycles.
- Back-to-back neurons: the earliest next start is sampled in the cycle after the out handshake, giving a throughput of N_IN+2 cycles per neuron.
- out_valid must not depend combinationally on out_ready.
- in_ready depends only on registered state and ena.
- ena=0 for any cycle: no state, counter or accumulator change. A pending out handshake does not complete in that cycle.
- cnt width is clog2(N_IN+1). It never wraps within a neuron.

## Test plan

Unless stated otherwise, parameters are N_IN=4, SHIFT=2, DATA_W=8, ACC_W=24.

- Basic: bias=0, relu_en=1, 4 beats of act=10 and wgt=3 → acc=120, out_data=30, out_ovf=0. out_valid first rises 5 cycles after start is sampled.
- Negative, both modes: act=10, wgt=-3 (0xFD), bias=0 → ReLU gives out_data=0x00; signed mode gives out_data=0xE2 (-30).
- Output clamp: act=255, wgt=127, ReLU → out_data=0xFF. The same stimulus in signed mode → 0x7F. out_ovf=0 in both.
- Accumulator saturation: ACC_W=17, bias=65000, act=255, wgt=127 ×4 → acc=65535, out_ovf=1. Both modes clamp the output: ReLU → 0xFF; signed → 0x7F.
- Handshakes: in_valid toggled 1-0-1-0 → exactly 4 beats accepted with no loss. out_ready held low 5 cycles → out_valid and out_data stable throughout, and start pulses in that window are ignored. Then out_ready=1 → IDLE next cycle.
- Reset/enable: rst_n=0 after beat 2 → all outputs at reset values next cycle. A fresh start then yields the basic result of 30. ena=0 for 3 cycles mid-ACCUM → latency extends by exactly 3 cycles with the same result.
